// File: rtl/usb_ulpi_pkg.sv
// Shared ULPI constants and the state encoding for the link-side register/NOPID
// transmit sequencer.
package usb_ulpi_pkg;

  localparam logic [7:0] TXCMD_NOPID = 8'h40;
  localparam logic [7:0] TXCMD_REGW  = 8'h80;
  localparam logic [7:0] TXCMD_REGR  = 8'hC0;

  localparam logic [5:0] FUNC_CTRL = 6'h04;
  localparam logic [5:0] OTG_CTRL  = 6'h0A;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_DATA     = 4'd2,
    ST_STOP     = 4'd3,
    ST_NOP_CMD  = 4'd4,
    ST_NOP_HOLD = 4'd5,
    ST_NOP_STOP = 4'd6,
    ST_RETRY    = 4'd7,
    ST_ABORT    = 4'd8
  } tx_state_e;

endpackage

// File: rtl/ulpi_reg_tx.sv
// ULPI link transmit sequencer: immediate register writes and NOPID chirp transmit,
// with dir turnaround, retry after PHY bus grab, and nxt timeout.
module ulpi_reg_tx
  import usb_ulpi_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o,
  input  logic       phy_write_i,
  input  logic       phy_nopid_i,
  input  logic       phy_stop_i,
  input  logic [7:0] phy_addr_i,
  input  logic [7:0] phy_data_i,
  output logic       phy_busy_o,
  output logic       phy_done_o,
  output logic       phy_error_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  tx_state_e      state_q, state_d;
  logic           dir_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           nop_q, nop_d;
  logic           wr_lock_q, wr_lock_d;
  logic           nop_lock_q, nop_lock_d;
  logic [7:0]     data_q, data_d;
  logic           stp_q, stp_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic bus_free;
  logic tmo;
  logic counting;
  logic req_live;

  assign bus_free = !ulpi_dir && !dir_q;
  assign tmo      = (cnt_q == TMO_LAST);
  assign counting = (state_q == ST_CMD) || (state_q == ST_DATA) || (state_q == ST_NOP_CMD);
  assign req_live = nop_q ? phy_nopid_i : phy_write_i;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      nop_q      <= 1'b0;
      wr_lock_q  <= 1'b0;
      nop_lock_q <= 1'b0;
      data_q     <= 8'h00;
      stp_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= ulpi_dir;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      nop_q      <= nop_d;
      wr_lock_q  <= wr_lock_d;
      nop_lock_q <= nop_lock_d;
      data_q     <= data_d;
      stp_q      <= stp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // dir beats nxt, nxt beats timeout, in every phase that waits on the PHY.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    nop_d   = nop_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_free && phy_write_i && !wr_lock_q) begin
          addr_d  = phy_addr_i;
          wdata_d = phy_data_i;
          nop_d   = 1'b0;
          state_d = ST_CMD;
        end else if (bus_free && phy_nopid_i && !nop_lock_q) begin
          nop_d   = 1'b1;
          state_d = ST_NOP_CMD;
        end
      end
      ST_CMD: begin
        if (ulpi_dir)      state_d = ST_RETRY;
        else if (ulpi_nxt) state_d = ST_DATA;
        else if (tmo)      state_d = ST_ABORT;
      end
      ST_DATA: begin
        if (ulpi_dir)      state_d = ST_RETRY;
        else if (ulpi_nxt) state_d = ST_STOP;
        else if (tmo)      state_d = ST_ABORT;
      end
      ST_NOP_CMD: begin
        if (ulpi_dir)      state_d = ST_RETRY;
        else if (ulpi_nxt) state_d = ST_NOP_HOLD;
        else if (tmo)      state_d = ST_ABORT;
      end
      ST_NOP_HOLD: begin
        if (ulpi_dir)        state_d = ST_RETRY;
        else if (phy_stop_i) state_d = ST_NOP_STOP;
      end
      ST_RETRY: begin
        if (!req_live)     state_d = ST_IDLE;
        else if (bus_free) state_d = nop_q ? ST_NOP_CMD : ST_CMD;
      end
      ST_STOP, ST_NOP_STOP, ST_ABORT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (counting && (state_d == state_q)) cnt_d = cnt_q + CW'(1);
  end

  // Outputs are a registered decode of the state being entered.
  always_comb begin
    data_d = 8'h00;
    stp_d  = 1'b0;
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      ST_CMD:      data_d = addr_d;
      ST_DATA:     data_d = wdata_d;
      ST_NOP_CMD:  data_d = TXCMD_NOPID;
      ST_NOP_HOLD: done_d = (state_q == ST_NOP_CMD);
      ST_STOP: begin
        stp_d  = 1'b1;
        done_d = 1'b1;
      end
      ST_NOP_STOP: stp_d = 1'b1;
      ST_ABORT: begin
        stp_d = 1'b1;
        err_d = 1'b1;
      end
      default: ;
    endcase
  end

  // A completed request must drop for a cycle before it can start again.
  always_comb begin
    wr_lock_d  = (state_d == ST_STOP) || (wr_lock_q && phy_write_i);
    nop_lock_d = (done_d && (state_d == ST_NOP_HOLD)) || (nop_lock_q && phy_nopid_i);
  end

  assign ulpi_data_o = data_q;
  assign ulpi_stp_o  = stp_q;
  assign phy_busy_o  = busy_q;
  assign phy_done_o  = done_q;
  assign phy_error_o = err_q;

endmodule

// File: doc/ulpi_reg_tx.md
Name: ulpi_reg_tx

Overview:
- Link-side ULPI transmit sequencer, directly downstream of the line-state/PHY-init FSM.
- Consumes its write/NOPID/stop requests (address = full TX CMD byte, e.g. 0x84, 0x8A) and drives the ULPI data/stp pins with correct bus-ownership and turnaround.
- Returns the busy/done handshake to the line-state FSM.
- Covers immediate register writes and the NOPID chirp-K transmit used during HS negotiation.

Parameters:
- TIMEOUT, 255: maximum cycles to wait for ulpi_nxt in any command/data phase before aborting (≥2). Counter width is $clog2(TIMEOUT+1).

Ports:
- clock  in  1  ULPI 60 MHz clock.
- reset_n  in  1  synchronous, active-low reset.
- ulpi_dir  in  1  raw PHY dir (1 = PHY owns bus).
- ulpi_nxt  in  1  raw PHY nxt.
- ulpi_data_o  out  8  link-driven ULPI data, registered.
- ulpi_stp_o  out  1  link stp, registered.
- phy_write_i  in  1  register-write request, level, held until done.
- phy_nopid_i  in  1  NOPID (chirp) transmit request, level, held until done.
- phy_stop_i  in  1  one-cycle pulse: terminate NOPID transmit.
- phy_addr_i  in  8  TX CMD byte for write (0x80|regaddr).
- phy_data_i  in  8  register value.
- phy_busy_o  out  1  sequence in progress.
- phy_done_o  out  1  one-cycle completion pulse.
- phy_error_o  out  1  one-cycle timeout pulse.

Behaviour:
- Reset (reset_n=0 at a clock edge) → state IDLE; ulpi_data_o=0x00, ulpi_stp_o=0, busy=0, done=0, error=0, dir_q=0, timeout count 0. Reset mid-sequence drops the sequence immediately and drives no stp.
- dir_q is ulpi_dir registered internally. bus_free = !ulpi_dir && !dir_q, which gives one turnaround cycle after dir falls.
- IDLE:
  - data=0x00, stp=0.
  - If bus_free and phy_write_i: latch addr/data, drive ulpi_data_o=addr, busy=1 → CMD.
  - Else if bus_free and phy_nopid_i: drive 0x40, busy=1 → NOP_CMD.
  - Write has priority when both requests are high.
- CMD:
  - Hold addr.
  - ulpi_nxt=1 (with ulpi_dir=0) → drive data next cycle → DATA.
- DATA:
  - Hold data.
  - ulpi_nxt=1 → STOP, driving data=0x00 and stp=1 for exactly one cycle.
- STOP:
  - done=1 for this single cycle; stp=0 next cycle; busy=0 → IDLE.
- NOP_CMD:
  - Hold 0x40.
  - ulpi_nxt=1 → NOP_HOLD, driving 0x00.
  - done pulses in the first NOP_HOLD cycle.
- NOP_HOLD:
  - Drive 0x00, busy=1.
  - phy_stop_i=1 → NOP_STOP (stp=1, data=0x00, one cycle) → IDLE.
  - phy_stop_i in any other state is ignored.
- Dir abort: ulpi_dir=1 in CMD, DATA, NOP_CMD or NOP_HOLD.
  - Next cycle: data=0x00, stp=0 → RETRY. No done, no error.
- RETRY:
  - busy stays 1.
  - When bus_free: write requests restart at CMD with the latched values; NOPID restarts at NOP_CMD.
  - Request deasserted meanwhile → IDLE.
  - No retry limit.
- Timeout:
  - Counter clears on every state entry and increments each cycle in CMD, DATA or NOP_CMD.
  - Reaching TIMEOUT without nxt → one-cycle stp=1, error=1, data=0x00 → IDLE (busy=0).
  - Requester may re-issue.
- Simultaneous nxt and dir in the same cycle: dir wins (abort).
- done and error are never high together.
- Once seen in IDLE, phy_done_o is not reasserted until the request was low for at least one cycle.

Decomposition:
- Package usb_ulpi_pkg:
  - TX CMD constants: TXCMD_NOPID=8'h40, TXCMD_REGW=8'h80, TXCMD_REGR=8'hC0.
  - Register addresses: FUNC_CTRL=6'h04, OTG_CTRL=6'h0A.
  - State encoding for this block.
- No sub-module required.
- Timeout counter stays inline; extract it as ulpi_nxt_timer only if reused by a future read sequencer.

Test Plan:
- Write, nxt after 2 cycles each phase: addr 0x84, data 0x45 → ulpi_data_o 0x84,0x84,0x45,0x45,0x00 with stp=1 on last; done once; busy 5 cycles.
- dir rises during DATA for 4 cycles, then falls: stp stays 0 → after dir low plus 1 turnaround cycle, 0x84 reissued, then full write completes with a single done.
- NOPID: nopid_i=1, nxt on 1st cycle → 0x40 then 0x00; done in first 0x00 cycle; phy_stop_i pulse 100 cycles later → one stp=1 cycle, data 0x00, busy falls.
- TIMEOUT=8, nxt never asserted: 8 cycles of 0x8A → stp=1 and error=1 for one cycle, no done, busy=0 next cycle.
- Write and nopid asserted together while dir=1: nothing driven until 2 cycles after dir falls; write 0x8A/0x00 runs first.
- reset_n low during NOP_HOLD: next cycle data=0x00, stp=0, busy=0; phy_stop_i afterwards has no effect.
